// File: rtl/routed_fifo_demux.sv
// Buffered 1-to-N packet router: one write port feeds NUM_PORTS independent
// first-word-fall-through FIFOs, each with its own valid/ready output handshake.
module routed_fifo_demux #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = $clog2(NUM_PORTS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [DATA_WIDTH-1:0]           din,
  input  logic                            din_en,
  input  logic [ADDR_W-1:0]               addr,
  output logic                            din_ready,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] dout,
  output logic [NUM_PORTS-1:0]            dout_valid,
  input  logic [NUM_PORTS-1:0]            dout_ready,
  output logic [7:0]                      drop_count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [NUM_PORTS-1:0] full;
  logic                 addr_hit;
  logic                 sel_full;
  logic                 accept;
  logic [7:0]           drop_q, drop_d;

  // Decode addr by comparison so out-of-range addresses never index past full[].
  always_comb begin
    addr_hit = 1'b0;
    sel_full = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (addr == ADDR_W'(i)) begin
        addr_hit = 1'b1;
        sel_full = full[i];
      end
    end
  end

  assign din_ready = addr_hit ? !sel_full : 1'b1;
  assign accept    = din_en && din_ready;

  always_comb begin
    drop_d = drop_q;
    if (accept && !addr_hit && drop_q != 8'hFF) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_q <= 8'd0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign drop_count = drop_q;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_chan
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  push;
    logic                  pop;

    assign full[g]       = (cnt_q == CntW'(FIFO_DEPTH));
    assign dout_valid[g] = (cnt_q != '0);
    assign push          = accept && addr_hit && (addr == ADDR_W'(g));
    assign pop           = dout_valid[g] && dout_ready[g];

    always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + CntW'(1);
        2'b01:   cnt_d = cnt_q - CntW'(1);
        default: cnt_d = cnt_q;
      endcase
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        cnt_q    <= cnt_d;
      end
    end

    // Storage is left unreset; stale words are masked by the zeroed count.
    always_ff @(posedge clk) begin
      if (push) begin
        mem_q[wr_ptr_q] <= din;
      end
    end

    assign dout[g*DATA_WIDTH +: DATA_WIDTH] = dout_valid[g] ? mem_q[rd_ptr_q] : '0;
  end

endmodule

// File: tb/tb_routed_fifo_demux.sv
// Directed bench for routed_fifo_demux: a 4-port and a 3-port instance share clock and reset.
module tb_routed_fifo_demux;

  logic         clk = 1'b0;
  logic         reset;

  logic [31:0]  din;
  logic         din_en;
  logic [1:0]   addr;
  logic         din_ready;
  logic [127:0] dout;
  logic [3:0]   dout_valid;
  logic [3:0]   dout_ready;
  logic [7:0]   drop_count;

  logic [31:0]  din3;
  logic         din_en3;
  logic [1:0]   addr3;
  logic         din_ready3;
  logic [95:0]  dout3;
  logic [2:0]   dout_valid3;
  logic [2:0]   dout_ready3;
  logic [7:0]   drop_count3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  routed_fifo_demux #(
    .DATA_WIDTH(32),
    .NUM_PORTS (4),
    .FIFO_DEPTH(4)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .din_en    (din_en),
    .addr      (addr),
    .din_ready (din_ready),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .drop_count(drop_count)
  );

  routed_fifo_demux #(
    .DATA_WIDTH(32),
    .NUM_PORTS (3),
    .FIFO_DEPTH(4)
  ) u_dut3 (
    .clk       (clk),
    .reset     (reset),
    .din       (din3),
    .din_en    (din_en3),
    .addr      (addr3),
    .din_ready (din_ready3),
    .dout      (dout3),
    .dout_valid(dout_valid3),
    .dout_ready(dout_ready3),
    .drop_count(drop_count3)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ch(input int idx);
    return dout[idx*32 +: 32];
  endfunction

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    din = '0; din_en = 1'b0; addr = '0; dout_ready = '0;
    din3 = '0; din_en3 = 1'b0; addr3 = '0; dout_ready3 = '0;
    #12;

    // Reset state
    check("rst_valid", dout_valid, 4'b0000);
    check("rst_dout", dout, 128'h0);
    check("rst_drop", drop_count, 8'd0);
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a);
      #1;
      check($sformatf("rst_ready_a%0d", a), din_ready, 1'b1);
    end
    tick();
    reset = 1'b0;
    tick();

    // One word into each channel
    for (int i = 0; i < 4; i++) begin
      din = 32'hA0 + 32'(i); addr = 2'(i); din_en = 1'b1;
      #1;
      check($sformatf("ab_ready%0d", i), din_ready, 1'b1);
      tick();
      if (i == 0) check("ab_latency_v", dout_valid, 4'b0001);
    end
    din_en = 1'b0;
    #1;
    check("ab_valid", dout_valid, 4'b1111);
    check("ab_dout", dout, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    check("ab_drop", drop_count, 8'd0);
    dout_ready = 4'b1111;
    tick();
    dout_ready = 4'b0000;
    check("ab_drained", dout_valid, 4'b0000);

    // Fill channel 2, stall the fifth word, then release one slot
    for (int i = 0; i < 4; i++) begin
      din = 32'h10 + 32'(i); addr = 2'd2; din_en = 1'b1;
      #1;
      check($sformatf("full_acc%0d", i), din_ready, 1'b1);
      tick();
    end
    din = 32'h14;
    #1;
    check("full_blocked", din_ready, 1'b0);
    check("full_head", ch(2), 32'h10);
    tick();
    dout_ready[2] = 1'b1;
    #1;
    check("full_no_passthru", din_ready, 1'b0);
    tick();
    dout_ready[2] = 1'b0;
    #1;
    check("full_ready_rise", din_ready, 1'b1);
    check("full_head2", ch(2), 32'h11);
    tick();
    din_en = 1'b0;
    dout_ready[2] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("full_drain%0d", i), ch(2), 32'h11 + 32'(i));
      tick();
    end
    dout_ready[2] = 1'b0;
    check("full_empty", dout_valid[2], 1'b0);

    // Channel 1 stalled full; channel 0 must keep flowing
    for (int i = 0; i < 4; i++) begin
      din = 32'h20 + 32'(i); addr = 2'd1; din_en = 1'b1;
      tick();
    end
    #1;
    check("hol_ch1_full", din_ready, 1'b0);
    dout_ready[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      din = 32'h30 + 32'(i); addr = 2'd0; din_en = 1'b1;
      #1;
      check($sformatf("hol_ready%0d", i), din_ready, 1'b1);
      tick();
      check($sformatf("hol_ch0_%0d", i), ch(0), 32'h30 + 32'(i));
    end
    din_en = 1'b0;
    tick();
    dout_ready[0] = 1'b0;
    check("hol_ch0_empty", dout_valid[0], 1'b0);
    check("hol_ch1_head", ch(1), 32'h20);
    dout_ready[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("hol_ch1_drain%0d", i), ch(1), 32'h20 + 32'(i));
      tick();
    end
    dout_ready[1] = 1'b0;
    check("hol_ch1_empty", dout_valid[1], 1'b0);

    // Back-to-back stream on channel 3 wraps the pointers four times
    dout_ready[3] = 1'b1;
    for (int k = 0; k < 16; k++) begin
      din = 32'(k); addr = 2'd3; din_en = 1'b1;
      #1;
      check($sformatf("strm_ready%0d", k), din_ready, 1'b1);
      tick();
      check($sformatf("strm_dout%0d", k), ch(3), 32'(k));
    end
    din_en = 1'b0;
    tick();
    dout_ready[3] = 1'b0;
    check("strm_empty", dout_valid, 4'b0000);

    // Out-of-range address on the 3-port instance
    addr3 = 2'd3; din3 = 32'hDEAD; din_en3 = 1'b1;
    for (int k = 0; k < 300; k++) begin
      #1;
      check("drop_ready", din_ready3, 1'b1);
      tick();
      check("drop_valid", dout_valid3, 3'b000);
      if (k == 9) check("drop_cnt10", drop_count3, 8'd10);
    end
    din_en3 = 1'b0;
    check("drop_sat", drop_count3, 8'd255);
    check("drop_dout", dout3, 96'h0);
    addr3 = 2'd2; din3 = 32'h77; din_en3 = 1'b1;
    tick();
    din_en3 = 1'b0;
    check("drop_valid_addr", dout3, {32'h77, 64'h0});
    check("drop_sat_hold", drop_count3, 8'd255);

    // Asynchronous reset mid-operation
    for (int i = 0; i < 4; i++) begin
      din = 32'h60 + 32'(i); addr = (i < 2) ? 2'd0 : 2'd2; din_en = 1'b1;
      tick();
    end
    din_en = 1'b0;
    #1;
    check("ar_pre_valid", dout_valid, 4'b0101);
    #2;
    reset = 1'b1;
    #1;
    check("ar_valid", dout_valid, 4'b0000);
    check("ar_dout", dout, 128'h0);
    check("ar_drop3", drop_count3, 8'd0);
    check("ar_valid3", dout_valid3, 3'b000);
    tick();
    reset = 1'b0;
    din = 32'h55; addr = 2'd0; din_en = 1'b1;
    tick();
    din_en = 1'b0;
    check("ar_new_valid", dout_valid, 4'b0001);
    check("ar_new_head", ch(0), 32'h55);
    dout_ready[0] = 1'b1;
    tick();
    dout_ready[0] = 1'b0;
    check("ar_no_stale", dout_valid, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
